// File: rtl/com_ser_rx_pkg.sv
// Shared constants and helpers for the angle telemetry receive path.
// The CRC constants match the transmit-side CRC block.
// Also holds the byte-receiver state encoding and a byte-wide CRC-8 step.
package com_ser_rx_pkg;

    localparam logic [7:0] CRC8_POLY     = 8'h07;
    localparam int         FRAME_BYTES   = 7;
    localparam int         PAYLOAD_BYTES = 6;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // CRC-8, MSB first, no reflection, no final xor: fold one whole byte in.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                               input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/com_ser_rx_uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, start/data/stop FSM, baud counter.
// Ports: clk, rst (async high), rx (raw line), rx_byte/byte_valid (stop bit good),
//        stop_err (stop bit sampled low), idle (FSM waiting for a start edge).
// byte_valid and stop_err are combinational strobes in the mid-stop-bit sample cycle.
module uart_rx_byte
    import com_ser_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       idle
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_state_e       state;
    rx_state_e       state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            cnt_clr;
    logic            shift_en;
    logic            half_done;
    logic            full_done;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign half_done = (bit_cnt == CW'(HALF_BIT - 1));
    assign full_done = (bit_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_nxt = RX_START;
                    cnt_clr   = 1'b1;
                end
            end
            RX_START: begin
                // Re-check mid start bit; a high line here was only a glitch.
                if (half_done) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (full_done) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (full_done) begin
                    cnt_clr    = 1'b1;
                    byte_valid = rx_sync;
                    stop_err   = !rx_sync;
                    state_nxt  = RX_IDLE;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_clr || state == RX_IDLE) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (state == RX_START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shreg <= {rx_sync, shreg[7:1]};
            end
        end
    end

    assign rx_byte = shreg;
    assign idle    = (state == RX_IDLE);

endmodule

// File: rtl/com_ser_rx.sv
// Angle telemetry receiver: assembles 7-byte frames (6 ASCII + CRC-8) and checks the CRC.
// Ports: clk, rst (async high), Rx (serial line), frame_data (held payload),
//        frame_valid / crc_err / frame_err (1-cycle pulses), busy (frame in progress).
// No flow control: consumers must latch frame_data on the frame_valid pulse.
module com_ser_rx
    import com_ser_rx_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rx,
    output logic [47:0] frame_data,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TMO_LIMIT + 1);
    localparam int CNT_W        = $clog2(FRAME_BYTES);

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             stop_err;
    logic             byte_idle;
    logic [CNT_W-1:0] byte_cnt;
    logic [47:0]      payload;
    logic [7:0]       crc;
    logic [TW-1:0]    tmo_cnt;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (Rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err),
        .idle       (byte_idle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            byte_cnt    <= '0;
            payload     <= '0;
            crc         <= '0;
            tmo_cnt     <= '0;
        end else begin
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;

            if (stop_err) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
                crc       <= '0;
                tmo_cnt   <= '0;
            end else if (byte_valid) begin
                tmo_cnt <= '0;
                if (byte_cnt == CNT_W'(PAYLOAD_BYTES)) begin
                    // Trailing byte is the CRC of the six payload bytes.
                    if (rx_byte == crc) begin
                        frame_data  <= payload;
                        frame_valid <= 1'b1;
                    end else begin
                        crc_err <= 1'b1;
                    end
                    byte_cnt <= '0;
                    crc      <= '0;
                end else begin
                    payload  <= {payload[39:0], rx_byte};
                    crc      <= crc8_update(crc, rx_byte);
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end else if (byte_cnt != '0 && byte_idle) begin
                // Gap counting only runs between bytes of a partially received frame.
                if (tmo_cnt == TW'(TMO_LIMIT)) begin
                    frame_err <= 1'b1;
                    byte_cnt  <= '0;
                    crc       <= '0;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Drops in the same cycle the end-of-frame pulse is raised.
    assign busy = (byte_cnt != '0) || !byte_idle;

endmodule
